// File: rtl/seg7_bcd_scanner_if.sv
// Request/result and display pin bundle for seg7_bcd_scanner.
// The master side supplies values to show; the slave side is the controller.
interface seg7_bcd_scanner_if #(
    parameter int unsigned NUM_WIDTH = 13,
    parameter int unsigned DIGITS    = 4
);
    logic [NUM_WIDTH-1:0] num;
    logic                 num_valid;
    logic                 signed_mode;
    logic                 blank_lz;
    logic                 busy;
    logic                 overflow;
    logic [DIGITS-1:0]    Anode;
    logic [6:0]           LED_out;

    modport master (
        output num, num_valid, signed_mode, blank_lz,
        input  busy, overflow, Anode, LED_out
    );

    modport slave (
        input  num, num_valid, signed_mode, blank_lz,
        output busy, overflow, Anode, LED_out
    );
endinterface

// File: rtl/seg7_bcd_scanner.sv
// Multiplexed common-anode seven-segment controller with an iterative
// shift-and-add-3 binary-to-BCD converter, sign, blanking and overflow display.
module seg7_bcd_scanner #(
    parameter int unsigned NUM_WIDTH    = 13,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic              clk,
    input  logic              rst,
    seg7_bcd_scanner_if.slave bus
);
    localparam int unsigned BCD_DIGITS = (NUM_WIDTH + 2) / 3 + 1;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned EXT_DIGITS = (BCD_DIGITS > DIGITS) ? BCD_DIGITS : DIGITS;
    localparam int unsigned EXT_W      = 4 * EXT_DIGITS;
    localparam int unsigned DISP_W     = 4 * DIGITS;
    localparam int unsigned CNT_W      = $clog2(NUM_WIDTH);
    localparam int unsigned IDX_W      = $clog2(DIGITS);

    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                  state_q, state_nxt;
    logic                    busy_q, busy_nxt;
    logic [NUM_WIDTH-1:0]    mag_q, mag_nxt;
    logic [BCD_W-1:0]        bcd_q, bcd_nxt;
    logic [CNT_W-1:0]        cnt_q, cnt_nxt;
    logic                    neg_q, neg_nxt;
    logic                    blank_q, blank_nxt;
    logic [DISP_W-1:0]       disp_q, disp_nxt;
    logic                    disp_neg_q, disp_neg_nxt;
    logic                    disp_blank_q, disp_blank_nxt;
    logic                    ovf_q, ovf_nxt;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_nxt;
    logic [IDX_W-1:0]        idx_q, idx_nxt;
    logic [DIGITS-1:0]       anode_q, anode_nxt;
    logic [6:0]              led_q, led_nxt;

    logic [BCD_W-1:0]        bcd_adj_c;
    logic [EXT_W-1:0]        bcd_ext_c;
    logic [IDX_W-1:0]        pos_c;
    logic [IDX_W-1:0]        hi_c;
    logic [3:0]              digit_c;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b0000001;
            4'd1:    seg_of = 7'b1001111;
            4'd2:    seg_of = 7'b0010010;
            4'd3:    seg_of = 7'b0000110;
            4'd4:    seg_of = 7'b1001100;
            4'd5:    seg_of = 7'b0100100;
            4'd6:    seg_of = 7'b0100000;
            4'd7:    seg_of = 7'b0001111;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0000100;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    // Add-3 correction of every BCD digit ahead of the shift.
    always_comb begin
        bcd_adj_c = bcd_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_ext_c = EXT_W'(bcd_q);
    end

    // Converter FSM: next state, work registers and commit of display registers.
    always_comb begin
        state_nxt      = state_q;
        busy_nxt       = busy_q;
        mag_nxt        = mag_q;
        bcd_nxt        = bcd_q;
        cnt_nxt        = cnt_q;
        neg_nxt        = neg_q;
        blank_nxt      = blank_q;
        disp_nxt       = disp_q;
        disp_neg_nxt   = disp_neg_q;
        disp_blank_nxt = disp_blank_q;
        ovf_nxt        = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.num_valid) begin
                    state_nxt = CONVERT;
                    busy_nxt  = 1'b1;
                    neg_nxt   = bus.signed_mode & bus.num[NUM_WIDTH-1];
                    mag_nxt   = neg_nxt ? (~bus.num) + NUM_WIDTH'(1) : bus.num;
                    blank_nxt = bus.blank_lz;
                    bcd_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            CONVERT: begin
                bcd_nxt = (bcd_adj_c << 1) | BCD_W'(mag_q[NUM_WIDTH-1]);
                mag_nxt = mag_q << 1;
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NUM_WIDTH - 1)) state_nxt = COMMIT;
            end
            COMMIT: begin
                state_nxt      = IDLE;
                busy_nxt       = 1'b0;
                disp_nxt       = bcd_ext_c[DISP_W-1:0];
                disp_neg_nxt   = neg_q;
                disp_blank_nxt = blank_q;
                ovf_nxt        = 1'b0;
                // The sign consumes the leftmost digit position.
                for (int i = 0; i < int'(EXT_DIGITS); i++) begin
                    if ((i >= (neg_q ? int'(DIGITS) - 1 : int'(DIGITS))) &&
                        (bcd_ext_c[4*i +: 4] != 4'd0)) ovf_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Scan sequencing and glyph selection, evaluated on next-state values so
    // anode and segments switch together on the same edge.
    always_comb begin
        refresh_nxt = refresh_q + REFRESH_BITS'(1);
        idx_nxt     = idx_q;
        if (&refresh_q) idx_nxt = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        pos_c     = IDX_W'(DIGITS - 1) - idx_nxt;
        anode_nxt = ~(DIGITS'(1) << pos_c);

        hi_c    = '0;
        digit_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if ((i > 0) && (disp_nxt[4*i +: 4] != 4'd0) &&
                !(disp_neg_nxt && (i == int'(DIGITS) - 1))) hi_c = IDX_W'(i);
            if (IDX_W'(i) == pos_c) digit_c = disp_nxt[4*i +: 4];
        end

        if (ovf_nxt || (disp_neg_nxt && (pos_c == IDX_W'(DIGITS - 1)))) led_nxt = SEG_DASH;
        else if (disp_blank_nxt && (pos_c > hi_c))                       led_nxt = SEG_BLANK;
        else                                                             led_nxt = seg_of(digit_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            mag_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            neg_q        <= 1'b0;
            blank_q      <= 1'b0;
            disp_q       <= '0;
            disp_neg_q   <= 1'b0;
            disp_blank_q <= 1'b0;
            ovf_q        <= 1'b0;
            refresh_q    <= '0;
            idx_q        <= '0;
            anode_q      <= '1;
            led_q        <= SEG_BLANK;
        end else begin
            state_q      <= state_nxt;
            busy_q       <= busy_nxt;
            mag_q        <= mag_nxt;
            bcd_q        <= bcd_nxt;
            cnt_q        <= cnt_nxt;
            neg_q        <= neg_nxt;
            blank_q      <= blank_nxt;
            disp_q       <= disp_nxt;
            disp_neg_q   <= disp_neg_nxt;
            disp_blank_q <= disp_blank_nxt;
            ovf_q        <= ovf_nxt;
            refresh_q    <= refresh_nxt;
            idx_q        <= idx_nxt;
            anode_q      <= anode_nxt;
            led_q        <= led_nxt;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
    assign bus.Anode    = anode_q;
    assign bus.LED_out  = led_q;
endmodule

// File: tb/tb_seg7_bcd_scanner.sv
// Randomized and directed bench for seg7_bcd_scanner: two instances (13-bit/4-digit
// and 20-bit/6-digit) compared every cycle against a decimal-arithmetic display model.
module tb_seg7_bcd_scanner;
    localparam int unsigned R   = 2;
    localparam int unsigned NW0 = 13;
    localparam int unsigned D0  = 4;
    localparam int unsigned NW1 = 20;
    localparam int unsigned D1  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_bcd_scanner_if #(.NUM_WIDTH(NW0), .DIGITS(D0)) bus0 ();
    seg7_bcd_scanner_if #(.NUM_WIDTH(NW1), .DIGITS(D1)) bus1 ();

    seg7_bcd_scanner #(.NUM_WIDTH(NW0), .DIGITS(D0), .REFRESH_BITS(R)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    seg7_bcd_scanner #(.NUM_WIDTH(NW1), .DIGITS(D1), .REFRESH_BITS(R)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint k        = 0;
    longint m_mag[2] = '{0, 0};
    bit     m_neg[2] = '{0, 0};
    bit     m_blk[2] = '{0, 0};
    bit     m_ovf[2] = '{0, 0};
    int     m_cnt[2] = '{0, 0};
    longint p_mag[2] = '{0, 0};
    bit     p_neg[2] = '{0, 0};
    bit     p_blk[2] = '{0, 0};

    function automatic int nw_of(input int i);
        return (i == 0) ? int'(NW0) : int'(NW1);
    endfunction
    function automatic int d_of(input int i);
        return (i == 0) ? int'(D0) : int'(D1);
    endfunction
    function automatic longint raw_of(input int i);
        return (i == 0) ? longint'(bus0.num) : longint'(bus1.num);
    endfunction
    function automatic bit sgn_of(input int i);
        return (i == 0) ? bus0.signed_mode : bus1.signed_mode;
    endfunction
    function automatic bit blk_of(input int i);
        return (i == 0) ? bus0.blank_lz : bus1.blank_lz;
    endfunction
    function automatic bit vld_of(input int i);
        return (i == 0) ? bus0.num_valid : bus1.num_valid;
    endfunction
    function automatic bit busy_of(input int i);
        return (i == 0) ? bus0.busy : bus1.busy;
    endfunction

    function automatic bit neg_of(input longint raw, input int n, input bit s);
        return s && raw[n-1];
    endfunction
    function automatic longint mag_of(input longint raw, input int n, input bit s);
        if (neg_of(raw, n, s)) return (longint'(1) << n) - raw;
        return raw;
    endfunction
    function automatic longint pow10(input int p);
        longint r = 1;
        for (int j = 0; j < p; j++) r = r * 10;
        return r;
    endfunction
    function automatic bit exp_ovf(input longint mag, input bit neg, input int d);
        return mag >= pow10(neg ? d - 1 : d);
    endfunction
    function automatic logic [6:0] seg(input int v);
        case (v)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  default: return 7'b0000100;
        endcase
    endfunction
    // p = decimal position, 0 = rightmost
    function automatic logic [6:0] exp_glyph(input int d, input int p, input longint mag,
                                             input bit neg, input bit blank, input bit ovf);
        int     ndig = 1;
        longint t    = mag;
        if (ovf) return 7'b1111110;
        if (neg && p == d - 1) return 7'b1111110;
        while (t >= 10) begin t = t / 10; ndig++; end
        if (blank && p >= ndig) return 7'b1111111;
        return seg(int'((mag / pow10(p)) % 10));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= 0;
            for (int i = 0; i < 2; i++) begin
                m_mag[i] <= 0; m_neg[i] <= 0; m_blk[i] <= 0; m_ovf[i] <= 0; m_cnt[i] <= 0;
            end
        end else begin
            k <= k + 1;
            for (int i = 0; i < 2; i++) begin
                if (m_cnt[i] != 0) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_mag[i] <= p_mag[i];
                        m_neg[i] <= p_neg[i];
                        m_blk[i] <= p_blk[i];
                        m_ovf[i] <= exp_ovf(p_mag[i], p_neg[i], d_of(i));
                    end
                end else if (vld_of(i)) begin
                    m_cnt[i] <= nw_of(i) + 1;
                    p_mag[i] <= mag_of(raw_of(i), nw_of(i), sgn_of(i));
                    p_neg[i] <= neg_of(raw_of(i), nw_of(i), sgn_of(i));
                    p_blk[i] <= blk_of(i);
                end
            end
        end
    end

    task automatic check_dut(input int i);
        int     d, p;
        longint an, led, bsy, ovf, full;
        d    = d_of(i);
        full = (longint'(1) << d) - 1;
        an   = (i == 0) ? longint'(bus0.Anode)    : longint'(bus1.Anode);
        led  = (i == 0) ? longint'(bus0.LED_out)  : longint'(bus1.LED_out);
        bsy  = (i == 0) ? longint'(bus0.busy)     : longint'(bus1.busy);
        ovf  = (i == 0) ? longint'(bus0.overflow) : longint'(bus1.overflow);
        if (rst) begin
            check($sformatf("d%0d_rst_anode", i), an, full);
            check($sformatf("d%0d_rst_led", i), led, 7'h7f);
            check($sformatf("d%0d_rst_busy", i), bsy, 0);
            check($sformatf("d%0d_rst_ovf", i), ovf, 0);
        end else begin
            p = d - 1 - int'((k >> R) % d);
            check($sformatf("d%0d_anode", i), an, full & ~(longint'(1) << p));
            check($sformatf("d%0d_led_pos%0d", i, p), led,
                  exp_glyph(d, p, m_mag[i], m_neg[i], m_blk[i], m_ovf[i]));
            check($sformatf("d%0d_busy", i), bsy, (m_cnt[i] != 0) ? 1 : 0);
            check($sformatf("d%0d_ovf", i), ovf, m_ovf[i] ? 1 : 0);
        end
    endtask

    always @(negedge clk) begin
        check_dut(0);
        check_dut(1);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int i, input longint v, input bit s, input bit b, input bit vld);
        if (i == 0) begin
            bus0.num = NW0'(v); bus0.signed_mode = s; bus0.blank_lz = b; bus0.num_valid = vld;
        end else begin
            bus1.num = NW1'(v); bus1.signed_mode = s; bus1.blank_lz = b; bus1.num_valid = vld;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input int i, input longint v, input bit s, input bit b);
        int guard = 0;
        while (busy_of(i) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("busy_timeout", 1, 0);
        drive(i, v, s, b, 1'b1);
        @(negedge clk);
        drive(i, longint'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rst = 1'b1;
        idle(3);
        #2 rst = 1'b0;
        idle(20);

        // Directed cases on the 4-digit instance.
        req(0, 1234, 0, 0);   idle(34);
        req(0, 7, 0, 1);      idle(34);
        req(0, -45, 1, 1);    idle(34);
        req(0, -45, 1, 0);    idle(20);
        req(0, 0, 0, 1);      idle(20);
        req(0, 8191, 0, 0);   idle(20);
        req(0, 8191, 1, 1);   idle(20);
        req(0, -999, 1, 0);   idle(20);
        req(0, -1000, 1, 0);  idle(20);
        req(0, -4096, 1, 1);  idle(20);
        req(0, 4096, 0, 1);   idle(20);

        // Request during conversion is dropped; next one accepted as soon as busy clears.
        req(0, 1234, 0, 0);
        idle(4);
        drive(0, 55, 0, 0, 1'b1);
        idle(1);
        drive(0, 0, 0, 0, 1'b0);
        req(0, 55, 0, 1);
        idle(20);

        // Reset in the middle of a conversion discards the partial result.
        req(0, 4321, 0, 0);
        req(1, 777777, 0, 0);
        idle(3);
        #2 rst = 1'b1;
        idle(2);
        #2 rst = 1'b0;
        idle(24);

        // Six-digit instance.
        req(1, 999999, 0, 0);   idle(50);
        req(1, -99999, 1, 1);   idle(30);
        req(1, 1048575, 0, 0);  idle(30);
        req(1, -524288, 1, 0);  idle(30);
        req(1, 42, 0, 1);       idle(30);

        // Randomized requests with random gaps on both instances.
        for (int n = 0; n < 60; n++) begin
            int     i;
            longint v;
            i = n % 2;
            case ($urandom_range(0, 2))
                0:       v = longint'($urandom_range(0, 20));
                1:       v = longint'($urandom_range(0, (1 << nw_of(i)) - 1));
                default: v = longint'((1 << nw_of(i)) - 1 - $urandom_range(0, 3));
            endcase
            req(i, v, 1'($urandom), 1'($urandom));
            idle(int'($urandom_range(0, 12)));
        end

        idle(60);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_bcd_scanner.md
# seg7_bcd_scanner

Parametrised multiplexed seven-segment display controller with a sequential binary-to-BCD converter. It accepts a binary value through a valid/busy handshake and converts it iteratively, one bit per cycle, using shift-and-add-3. It then drives a time-multiplexed common-anode display of DIGITS digits. Optional signed display, leading-zero blanking and overflow indication are supported. It sits at the top level between core debug/result registers and the board display pins.

## Interface
- NUM_WIDTH, 13: width of input value in bits (≥4).
- DIGITS, 4: number of display digits (2–8).
- REFRESH_BITS, 18: each digit is lit for 2^REFRESH_BITS clk cycles.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- num  in  NUM_WIDTH  value to display; sampled only on an accepted request.
- num_valid  in  1  load request.
- signed_mode  in  1  treat num as two's complement; sampled with num.
- blank_lz  in  1  leading-zero blanking enable; sampled with num.
- busy  out  1  conversion in progress; requests are ignored while high.
- overflow  out  1  last committed value did not fit the display.
- Anode  out  DIGITS  active-low digit enables, one-hot-low; Anode[DIGITS-1] is the leftmost digit.
- LED_out  out  7  active-low segments, bit6=a … bit0=g.

## Operation
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE → CONVERT when num_valid=1.
  - CONVERT → COMMIT after NUM_WIDTH shift steps.
  - COMMIT → IDLE unconditionally.
- On accept (IDLE, num_valid=1):
  - Capture magnitude: if signed_mode=1 and num[MSB]=1, magnitude = −num and neg=1; otherwise magnitude = num and neg=0.
  - −2^(NUM_WIDTH−1) has magnitude 2^(NUM_WIDTH−1), which fits NUM_WIDTH unsigned bits.
  - Clear BCD work register and bit counter.
- BCD work register holds ceil(NUM_WIDTH/3)+1 digits, so intermediate results can never overflow.
- Each CONVERT step:
  - Add 3 to every BCD digit ≥5.
  - Shift the whole register left by 1, inserting the next magnitude bit, MSB first.
- COMMIT computes the display outputs:
  - Available digits are DIGITS if neg=0, DIGITS−1 if neg=1.
  - overflow=1 if any BCD digit at index ≥ available digits is nonzero.
  - Display registers load the low DIGITS BCD digits, neg, blank_lz and overflow atomically.
  - The display shows the old value until this commit.
- Digit glyph, leftmost to rightmost:
  - If overflow: every digit shows dash, LED_out = 1111110.
  - Else, if neg: leftmost digit shows dash; remaining digits show magnitude digits.
  - Digit values 0–9 use the standard table (0 = 0000001, 1 = 1001111, 8 = 0000000, 9 = 0000100, …).
  - Leading-zero blanking applies when blank_lz=1:
    - Digits more significant than the highest nonzero magnitude digit show blank, LED_out = 1111111.
    - The rightmost digit always shows, so value 0 displays "0".
    - Blanking never removes the minus sign.
- Scan:
  - Free-running refresh counter.
  - Digit index advances every 2^REFRESH_BITS cycles, in order 0 (leftmost) … DIGITS−1, then wraps to 0. Wrap is exact for non-power-of-two DIGITS.
  - Anode drives only the indexed digit low; LED_out carries that digit's glyph.
  - Scan is independent of the converter and never stalls.

## Timing
- Reset values:
  - state = IDLE, busy = 0, overflow = 0.
  - Anode = all 1s, LED_out = 1111111 while rst is high.
  - Display registers = 0, neg = 0, blank_lz = 0; refresh counter and digit index = 0.
- After reset release, the display shows all zeros with no blanking, leftmost digit first.
- Request timing:
  - Edge E0 accepts num_valid: busy=1 after E0.
  - Edges E1…E_NUM_WIDTH perform the shift steps.
  - Edge E_NUM_WIDTH+1 commits: display and overflow update, busy=0.
- busy is high for exactly NUM_WIDTH+1 cycles.
- The next request can be accepted at the first edge where busy=0 was seen, i.e. E_NUM_WIDTH+2.
- num_valid while busy=1 is dropped; there is no queueing.
- Inputs num, signed_mode and blank_lz are don't-care outside the accept edge.
- rst asserted mid-conversion aborts to the reset state; the partial result is never committed.
- Anode and LED_out are registered: glyph and anode change on the same edge, with no 1-cycle ghosting.

## Test plan
- Reset: hold rst 3 cycles → Anode=1111, LED_out=1111111, busy=0. Release → digits show 0,0,0,0 in scan order.
- Basic convert (defaults, REFRESH_BITS=2): num=1234, unsigned → busy high 14 cycles; then per-digit LED_out = 1001111, 0010010, 0000110, 1001100 with Anode 0111, 1011, 1101, 1110; each digit held 4 cycles and the scan wraps.
- Blanking and sign:
  - num=7, blank_lz=1 → blank, blank, blank, "7".
  - signed_mode=1, num=−45 → "-", blank, "4", "5".
  - num=0, blank_lz=1 → only the rightmost digit shows "0".
- Overflow:
  - Unsigned 8191 → all four digits dash, overflow=1.
  - Signed −999 → "-999", overflow=0.
  - Signed −1000 → all dashes, overflow=1.
  - Signed −4096 → overflow=1.
- Handshake:
  - Pulse num_valid with 55 mid-conversion of 1234 → 1234 is committed and 55 is dropped.
  - Request 55 at E_NUM_WIDTH+2 → accepted.
- Reset mid-operation and parametrisation:
  - Assert rst during cycle 5 of a conversion → no commit, reset values restored.
  - Repeat the basic test with DIGITS=6, NUM_WIDTH=20, num=999999 → "999999" and correct wrap of the 6-digit scan.
